// File: rtl/adc_cfg_sched_if.sv
// Request/response and SPI-config-engine signal bundle for adc_cfg_sched.
// slave = scheduler side, master = requesters / config engine side.
interface adc_cfg_sched_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req0_ack;
  logic        req1_ack;
  logic [15:0] rsp_data;
  logic        cfg_start;
  logic [31:0] cfg_data;
  logic [15:0] cfg_rdata;
  logic        cfg_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, cfg_rdata,
    output req0_ack, req1_ack, rsp_data, cfg_start, cfg_data, cfg_ready, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, cfg_rdata,
    input  req0_ack, req1_ack, rsp_data, cfg_start, cfg_data, cfg_ready, busy
  );
endinterface

// File: rtl/adc_cfg_sched.sv
// Two-requester scheduler for the ADC SPI config engine, gated by a power-up delay.
// Define ADC_CFG_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module adc_cfg_sched #(
  parameter int unsigned XFER_CYCLES  = 48,
  parameter int unsigned PWRUP_CYCLES = 16128
) (
  input  logic           clk_sck,
  input  logic           rst_n,
  adc_cfg_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [23:0] PWRUP_LIM = 24'(PWRUP_CYCLES);
  localparam logic [7:0]  XFER_LD   = 8'(XFER_CYCLES);

  state_t      state, state_nxt;
  logic [23:0] pwr_cnt;
  logic [7:0]  wait_cnt;
  logic        grant1;
  logic [31:0] cfg_data_q;
  logic [15:0] rsp_data_q;
  logic        cfg_ready;
  logic        any_req;
  logic        pick1;
  logic        grant_ld;
  logic        wait_ld;
  logic        wait_dec;
  logic        rsp_ld;

  assign cfg_ready = (pwr_cnt == PWRUP_LIM);
  assign any_req   = bus.req0_valid | bus.req1_valid;

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      pwr_cnt <= '0;
    end else if (!cfg_ready) begin
      pwr_cnt <= pwr_cnt + 24'd1;
    end
  end

`ifdef ADC_CFG_RR_EN
  // last1 set means req1 was granted last, so req0 is preferred on a tie.
  logic last1;

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      last1 <= 1'b1;
    end else if (grant_ld) begin
      last1 <= pick1;
    end
  end

  always_comb begin
    pick1 = bus.req1_valid & (~bus.req0_valid | ~last1);
  end
`else
  always_comb begin
    pick1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_ld  = 1'b0;
    wait_ld   = 1'b0;
    wait_dec  = 1'b0;
    rsp_ld    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_ready && any_req) begin
          grant_ld  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wait_ld   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        wait_dec = 1'b1;
        if (wait_cnt == 8'd1) begin
          rsp_ld    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (wait_ld) begin
      wait_cnt <= XFER_LD;
    end else if (wait_dec) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  // Command word and grant are captured once at grant time; later requester
  // data changes cannot reach the config engine.
  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      cfg_data_q <= '0;
      grant1     <= 1'b0;
    end else if (grant_ld) begin
      cfg_data_q <= pick1 ? bus.req1_data : bus.req0_data;
      grant1     <= pick1;
    end
  end

  always_ff @(posedge clk_sck) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
    end else if (rsp_ld) begin
      rsp_data_q <= bus.cfg_rdata;
    end
  end

  assign bus.cfg_start = (state == ISSUE);
  assign bus.busy      = (state != IDLE);
  assign bus.req0_ack  = (state == DONE) & ~grant1;
  assign bus.req1_ack  = (state == DONE) & grant1;
  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
